// File: rtl/pcie_rx_com_sync_if.sv
// Byte-stream bus between the byte receiver, the COM lock stage and its consumer.
interface pcie_rx_com_sync_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       data_in;
  logic             valid_in;
  logic [7:0]       data_out;
  logic             valid_out;
  logic             synced;
  logic [CNT_W-1:0] rx_count;

  modport master (
    output data_in, valid_in,
    input  data_out, valid_out, synced, rx_count
  );

  modport slave (
    input  data_in, valid_in,
    output data_out, valid_out, synced, rx_count
  );
endinterface

// File: rtl/pcie_rx_com_sync.sv
// RX symbol lock: acquires lock on a run of COM symbols, then forwards payload
// bytes with COMs stripped, and drops lock after a run of idle cycles.
module pcie_rx_com_sync #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         COM_LOCK   = 4,
  parameter int         LOSS_LIMIT = 8,
  parameter int         CNT_W      = 16
) (
  input logic                CLK,
  input logic                reset,
  pcie_rx_com_sync_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ALIGN, SYNC} state_t;

  localparam logic [4:0] LOCK_N = 5'(COM_LOCK);
  localparam logic [8:0] LOSS_N = 9'(LOSS_LIMIT);

  state_t     state;
  logic [3:0] com_cnt;
  logic [7:0] idle_cnt;

  logic       is_com, is_dat, is_gap;
  logic [4:0] com_nxt;
  logic [8:0] idle_nxt;

  assign is_com   = bus.valid_in && (bus.data_in == COM);
  assign is_dat   = bus.valid_in && (bus.data_in != COM);
  assign is_gap   = !bus.valid_in;
  assign com_nxt  = {1'b0, com_cnt} + 5'd1;
  assign idle_nxt = {1'b0, idle_cnt} + 9'd1;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= IDLE;
      com_cnt       <= '0;
      idle_cnt      <= '0;
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
      bus.synced    <= 1'b0;
      bus.rx_count  <= '0;
    end else begin
      // valid_out is a single-cycle strobe; only a forwarded DAT raises it
      bus.valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (is_com) begin
            com_cnt <= 4'd1;
            if (LOCK_N == 5'd1) begin
              state        <= SYNC;
              bus.synced   <= 1'b1;
              bus.rx_count <= '0;
              idle_cnt     <= '0;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (is_com) begin
            com_cnt <= com_nxt[3:0];
            if (com_nxt == LOCK_N) begin
              state        <= SYNC;
              bus.synced   <= 1'b1;
              bus.rx_count <= '0;
              idle_cnt     <= '0;
            end
          end else if (is_dat) begin
            // a payload byte breaks the COM run; a gap merely stalls it
            state   <= IDLE;
            com_cnt <= '0;
          end
        end
        SYNC: begin
          if (is_dat) begin
            bus.data_out  <= bus.data_in;
            bus.valid_out <= 1'b1;
            bus.rx_count  <= bus.rx_count + 1'b1;
            idle_cnt      <= '0;
          end else if (is_com) begin
            idle_cnt <= '0;
          end else if (is_gap) begin
            if (idle_nxt == LOSS_N) begin
              state      <= IDLE;
              bus.synced <= 1'b0;
              com_cnt    <= '0;
              idle_cnt   <= '0;
            end else begin
              idle_cnt <= idle_nxt[7:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_rx_com_sync.sv
// Directed bench for pcie_rx_com_sync: default DUT plus a boundary-parameter DUT.
module tb_pcie_rx_com_sync;
  logic CLK = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pcie_rx_com_sync_if #(.CNT_W(16)) bus ();
  pcie_rx_com_sync_if #(.CNT_W(2))  bus2 ();

  pcie_rx_com_sync #(.COM(8'hBC), .COM_LOCK(4), .LOSS_LIMIT(8), .CNT_W(16)) u_dut (
    .CLK(CLK), .reset(reset), .bus(bus.slave)
  );

  // lock on a single COM, drop on a single gap, 2-bit counter to hit the wrap
  pcie_rx_com_sync #(.COM(8'hBC), .COM_LOCK(1), .LOSS_LIMIT(1), .CNT_W(2)) u_dut2 (
    .CLK(CLK), .reset(reset), .bus(bus2.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic v);
    bus.data_in   = d;
    bus.valid_in  = v;
    bus2.data_in  = d;
    bus2.valid_in = v;
    @(posedge CLK);
    #1;
  endtask

  task automatic gaps(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0);
  endtask

  logic [7:0] pay [7] = '{8'hF9, 8'h4F, 8'hA6, 8'h39, 8'hA8, 8'hF9, 8'h4F};
  logic [7:0] brk [7] = '{8'hBC, 8'hBC, 8'h11, 8'hBC, 8'hBC, 8'hBC, 8'hBC};

  initial begin
    reset = 1'b1;
    step(8'h00, 1'b0);
    // T1: reset with random traffic
    for (int i = 0; i < 4; i++) step(8'($urandom), 1'($urandom));
    chk("t1_data_out",  bus.data_out, 0);
    chk("t1_valid_out", bus.valid_out, 0);
    chk("t1_synced",    bus.synced, 0);
    chk("t1_rx_count",  bus.rx_count, 0);
    reset = 1'b0;

    // T2: lock after four COMs, leading payload ignored
    step(8'h25, 1'b1);
    chk("t2_lead_valid", bus.valid_out, 0);
    for (int i = 0; i < 4; i++) begin
      step(8'hBC, 1'b1);
      chk($sformatf("t2_synced_%0d", i), bus.synced, (i == 3) ? 1 : 0);
      chk($sformatf("t2_valid_%0d", i), bus.valid_out, 0);
    end
    chk("t2_rx_count", bus.rx_count, 0);

    // T3: payload forwarded with one cycle latency
    for (int i = 0; i < 7; i++) begin
      step(pay[i], 1'b1);
      chk($sformatf("t3_data_%0d", i), bus.data_out, pay[i]);
      chk($sformatf("t3_valid_%0d", i), bus.valid_out, 1);
    end
    chk("t3_rx_count", bus.rx_count, 7);

    // T4: drop lock, then broken run; then a stalled run
    gaps(8);
    chk("t4_unlock", bus.synced, 0);
    chk("t4_rx_hold", bus.rx_count, 7);
    for (int i = 0; i < 7; i++) begin
      step(brk[i], 1'b1);
      chk($sformatf("t4_brk_synced_%0d", i), bus.synced, (i == 6) ? 1 : 0);
    end
    gaps(8);
    chk("t4_unlock2", bus.synced, 0);
    step(8'hBC, 1'b1);
    step(8'hBC, 1'b1);
    gaps(3);
    chk("t4_stall_synced", bus.synced, 0);
    step(8'hBC, 1'b1);
    chk("t4_stall_3rd", bus.synced, 0);
    step(8'hBC, 1'b1);
    chk("t4_stall_lock", bus.synced, 1);
    chk("t4_rx_clear", bus.rx_count, 0);

    // T5: COM stripping and loss of lock
    step(8'hA1, 1'b1);
    chk("t5_a1_data", bus.data_out, 8'hA1);
    chk("t5_a1_valid", bus.valid_out, 1);
    step(8'hBC, 1'b1);
    chk("t5_com_valid", bus.valid_out, 0);
    chk("t5_com_hold", bus.data_out, 8'hA1);
    step(8'hA2, 1'b1);
    chk("t5_a2_data", bus.data_out, 8'hA2);
    chk("t5_a2_valid", bus.valid_out, 1);
    chk("t5_rx_count", bus.rx_count, 2);
    gaps(7);
    chk("t5_gap7_synced", bus.synced, 1);
    chk("t5_gap7_valid", bus.valid_out, 0);
    gaps(1);
    chk("t5_gap8_synced", bus.synced, 0);
    chk("t5_rx_hold", bus.rx_count, 2);
    step(8'h55, 1'b1);
    chk("t5_nofwd_valid", bus.valid_out, 0);
    chk("t5_nofwd_data", bus.data_out, 8'hA2);

    // T6: reset while locked
    for (int i = 0; i < 4; i++) step(8'hBC, 1'b1);
    chk("t6_lock", bus.synced, 1);
    for (int i = 0; i < 5; i++) step(8'(8'h30 + i), 1'b1);
    chk("t6_rx5", bus.rx_count, 5);
    reset = 1'b1;
    step(8'h77, 1'b1);
    reset = 1'b0;
    chk("t6_synced", bus.synced, 0);
    chk("t6_rx_count", bus.rx_count, 0);
    chk("t6_valid", bus.valid_out, 0);
    chk("t6_data", bus.data_out, 0);

    // boundary DUT: single-COM lock, counter wrap, single-gap loss
    chk("b_reset_synced", bus2.synced, 0);
    step(8'hBC, 1'b1);
    chk("b_lock1", bus2.synced, 1);
    chk("b_main_nolock", bus.synced, 0);
    for (int i = 0; i < 5; i++) begin
      step(8'(8'hC0 + i), 1'b1);
      chk($sformatf("b_rx_%0d", i), bus2.rx_count, (i + 1) % 4);
    end
    chk("b_data", bus2.data_out, 8'hC4);
    gaps(1);
    chk("b_loss1", bus2.synced, 0);
    chk("b_rx_hold", bus2.rx_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
